// File: rtl/fp8_pkg.sv
// Shared definitions for the FP32 -> FP8 pack stage: default format, FP32 field
// layout, special-value encodings and per-sample status flags.
package fp8_pkg;

  localparam int E_DEF      = 4;
  localparam int M_DEF      = 3;
  localparam int BIAS_DEF   = (1 << (E_DEF - 1)) - 1;
  localparam int FP8_W      = 8;
  localparam int F32_W      = 32;
  localparam int F32_EXP_W  = 8;
  localparam int F32_FRAC_W = 23;
  localparam int F32_BIAS   = 127;
  localparam int T_W        = 10;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  typedef enum logic [2:0] {
    CLS_NORM = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_ZERO = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } cls_e;

  // {s, all-ones exponent, zero mantissa}
  function automatic logic [FP8_W-1:0] fp8_inf(input logic s, input int e, input int m);
    logic [FP8_W-1:0] r;
    for (int i = 0; i < FP8_W - 1; i++) begin
      r[i] = (i >= m) && (i < m + e);
    end
    r[FP8_W-1] = s;
    return r;
  endfunction

  function automatic logic [FP8_W-1:0] fp8_nan(input logic s, input int e, input int m);
    logic [FP8_W-1:0] r;
    r = fp8_inf(s, e, m);
    r[m-1] = 1'b1;
    return r;
  endfunction

  // Largest finite magnitude: exponent 2^E-2, mantissa all ones
  function automatic logic [FP8_W-1:0] fp8_max(input logic s, input int e, input int m);
    logic [FP8_W-1:0] r;
    for (int i = 0; i < FP8_W - 1; i++) begin
      r[i] = (i < m) || ((i > m) && (i < m + e));
    end
    r[FP8_W-1] = s;
    return r;
  endfunction

endpackage

// File: rtl/fp32_to_fp8_pack_round.sv
// Round-to-nearest-even on an aligned {exp, keep} pair; a mantissa carry
// ripples into the exponent field (subnormal -> min normal falls out here).
module fp8_round_rne
  import fp8_pkg::*;
#(
  parameter int E = E_DEF,
  parameter int M = M_DEF
) (
  input  logic [E-1:0] exp_pre,
  input  logic [M-1:0] keep,
  input  logic         guard,
  input  logic         sticky,
  output logic [E-1:0] exp_post,
  output logic [M-1:0] mant_post,
  output logic         carry,
  output logic         inexact
);

  logic         round_up_s;
  logic [E+M-1:0] sum_s;

  // RNE increment of the concatenated exponent/mantissa
  always_comb begin
    round_up_s = guard & (sticky | keep[0]);
    sum_s      = {exp_pre, keep} + {{(E+M-1){1'b0}}, round_up_s};
    exp_post   = sum_s[E+M-1:M];
    mant_post  = sum_s[M-1:0];
    carry      = round_up_s & (&keep);
    inexact    = guard | sticky;
  end

endmodule

// File: rtl/fp32_to_fp8_pack.sv
// Two-stage FP32 -> FP8 repack: stage 1 decodes and aligns, stage 2 rounds,
// handles specials/overflow and registers the packed result with flags.
module fp32_to_fp8_pack
  import fp8_pkg::*;
#(
  parameter int E        = E_DEF,
  parameter int M        = M_DEF,
  parameter int BIAS     = (1 << (E - 1)) - 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [F32_W-1:0] in_f32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP8_W-1:0] out_fp8,
  output logic [2:0]       out_flags
);

  localparam int SIG_W  = F32_FRAC_W + 1;
  localparam int SH_W   = 5;
  localparam int SH_MAX = M + 2;
  localparam logic signed [T_W-1:0] T_ONE   = T_W'(1);
  localparam logic signed [T_W-1:0] T_OVF   = T_W'((1 << E) - 1);
  localparam logic signed [T_W-1:0] T_SHMAX = T_W'(SH_MAX);
  localparam logic signed [T_W-1:0] T_ADJ   = T_W'(BIAS - F32_BIAS);
  localparam logic [E-1:0]          EXP_TOP = E'((1 << E) - 2);

  // handshake
  logic adv1_s, adv2_s;

  // stage-1 decode
  logic                   sign_s;
  logic [F32_EXP_W-1:0]   e8_s;
  logic [F32_FRAC_W-1:0]  f23_s;
  logic signed [T_W-1:0]  t_s, sh_full_s;
  logic [SH_W-1:0]        sh_s;
  logic [SIG_W-1:0]       sig_s, mask_s;
  logic [F32_FRAC_W-1:0]  sub_frac_s;
  logic                   lost_s;
  cls_e                   cls_s;
  logic [E-1:0]           exp_s;
  logic [M-1:0]           keep_s;
  logic                   guard_s, sticky_s, ovf_s;

  logic         s1_valid_r, s1_sign_r, s1_guard_r, s1_sticky_r, s1_ovf_r;
  cls_e         s1_cls_r;
  logic [E-1:0] s1_exp_r;
  logic [M-1:0] s1_keep_r;

  // stage-2 round/pack
  logic [E-1:0]     rnd_exp_s;
  logic [M-1:0]     rnd_mant_s;
  logic             rnd_carry_s, rnd_inexact_s;
  logic [FP8_W-1:0] res_s;
  flags_t           flags_s;

  logic             s2_valid_r;
  logic [FP8_W-1:0] out_fp8_r;
  flags_t           out_flags_r;

  // Pipeline advance enables; a full pipe with a stalled sink drops in_ready
  always_comb begin
    adv2_s   = !s2_valid_r || out_ready;
    adv1_s   = !s1_valid_r || adv2_s;
    in_ready = rst_n && adv1_s;
  end

  // Subnormal alignment: shift amount saturates once the leading one sits below guard
  always_comb begin
    sign_s    = in_f32[F32_W-1];
    e8_s      = in_f32[F32_W-2 -: F32_EXP_W];
    f23_s     = in_f32[F32_FRAC_W-1:0];
    t_s       = signed'({2'b00, e8_s}) + T_ADJ;
    sh_full_s = T_ONE - t_s;
    if (t_s >= T_ONE) begin
      sh_s = {SH_W{1'b0}};
    end else if (sh_full_s > T_SHMAX) begin
      sh_s = SH_W'(SH_MAX);
    end else begin
      sh_s = sh_full_s[SH_W-1:0];
    end
    sig_s      = {1'b1, f23_s};
    mask_s     = ({{(SIG_W-1){1'b0}}, 1'b1} << sh_s) - {{(SIG_W-1){1'b0}}, 1'b1};
    lost_s     = |(sig_s & mask_s);
    sub_frac_s = F32_FRAC_W'(sig_s >> sh_s);
  end

  // Classification and keep/guard/sticky extraction; flushed FP32 subnormals ride the zero path
  always_comb begin
    cls_s    = CLS_NORM;
    exp_s    = {E{1'b0}};
    keep_s   = {M{1'b0}};
    guard_s  = 1'b0;
    sticky_s = 1'b0;
    ovf_s    = 1'b0;
    if (e8_s == {F32_EXP_W{1'b1}}) begin
      cls_s = (f23_s != {F32_FRAC_W{1'b0}}) ? CLS_NAN : CLS_INF;
    end else if (e8_s == {F32_EXP_W{1'b0}}) begin
      cls_s    = CLS_ZERO;
      sticky_s = |f23_s;
    end else if (t_s >= T_ONE) begin
      cls_s    = CLS_NORM;
      exp_s    = t_s[E-1:0];
      keep_s   = f23_s[F32_FRAC_W-1 -: M];
      guard_s  = f23_s[F32_FRAC_W-1-M];
      sticky_s = |f23_s[F32_FRAC_W-2-M:0];
      ovf_s    = (t_s >= T_OVF);
    end else begin
      cls_s    = CLS_SUB;
      keep_s   = sub_frac_s[F32_FRAC_W-1 -: M];
      guard_s  = sub_frac_s[F32_FRAC_W-1-M];
      sticky_s = (|sub_frac_s[F32_FRAC_W-2-M:0]) | lost_s;
    end
  end

  // Stage-1 register: decoded fields of the accepted sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_sign_r   <= 1'b0;
      s1_cls_r    <= CLS_ZERO;
      s1_exp_r    <= {E{1'b0}};
      s1_keep_r   <= {M{1'b0}};
      s1_guard_r  <= 1'b0;
      s1_sticky_r <= 1'b0;
      s1_ovf_r    <= 1'b0;
    end else if (adv1_s) begin
      s1_valid_r  <= in_valid;
      s1_sign_r   <= sign_s;
      s1_cls_r    <= cls_s;
      s1_exp_r    <= exp_s;
      s1_keep_r   <= keep_s;
      s1_guard_r  <= guard_s;
      s1_sticky_r <= sticky_s;
      s1_ovf_r    <= ovf_s;
    end
  end

  fp8_round_rne #(
    .E(E),
    .M(M)
  ) u_round (
    .exp_pre  (s1_exp_r),
    .keep     (s1_keep_r),
    .guard    (s1_guard_r),
    .sticky   (s1_sticky_r),
    .exp_post (rnd_exp_s),
    .mant_post(rnd_mant_s),
    .carry    (rnd_carry_s),
    .inexact  (rnd_inexact_s)
  );

  // Result select: specials, overflow policy, then the rounded finite value
  always_comb begin
    res_s   = {s1_sign_r, rnd_exp_s, rnd_mant_s};
    flags_s = '0;
    case (s1_cls_r)
      CLS_NAN: begin
        res_s = fp8_nan(s1_sign_r, E, M);
      end
      CLS_INF: begin
        res_s = fp8_inf(s1_sign_r, E, M);
      end
      CLS_NORM, CLS_SUB, CLS_ZERO: begin
        if (s1_ovf_r || (rnd_carry_s && (s1_exp_r == EXP_TOP))) begin
          res_s            = (SATURATE != 0) ? fp8_max(s1_sign_r, E, M) : fp8_inf(s1_sign_r, E, M);
          flags_s.overflow = 1'b1;
          flags_s.inexact  = 1'b1;
        end else begin
          flags_s.inexact   = rnd_inexact_s;
          flags_s.underflow = rnd_inexact_s && (s1_exp_r == {E{1'b0}});
        end
      end
      default: begin
        res_s = {FP8_W{1'b0}};
      end
    endcase
  end

  // Stage-2 register: output holds while the sink stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r  <= 1'b0;
      out_fp8_r   <= {FP8_W{1'b0}};
      out_flags_r <= '0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_fp8_r   <= res_s;
        out_flags_r <= flags_s;
      end
    end
  end

  assign out_valid = s2_valid_r;
  assign out_fp8   = out_fp8_r;
  assign out_flags = out_flags_r;

endmodule

// File: tb/tb_fp32_to_fp8_pack.sv
// Directed bench for fp32_to_fp8_pack (E4M3): scoreboard of expected results,
// stall/backpressure stream and reset-while-full, checked on two overflow policies.
module tb_fp32_to_fp8_pack;

  typedef struct packed {
    logic [31:0] f32;
    logic [7:0]  fp8;
    logic [2:0]  flg;
    logic [7:0]  sat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [31:0] in_f32;
  logic        in_ready, out_valid, in_ready_sat, out_valid_sat;
  logic [7:0]  out_fp8, out_fp8_sat;
  logic [2:0]  out_flags, out_flags_sat;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   occ      = 0;
  int   rdy_mode = 0;
  int   ph       = 0;
  vec_t sb[$];
  vec_t vecs[19];
  vec_t mon_e;
  logic       stalled = 1'b0;
  logic [7:0] held_fp8;
  logic [2:0] held_flags;

  fp32_to_fp8_pack #(.SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_f32(in_f32),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp8(out_fp8), .out_flags(out_flags)
  );

  fp32_to_fp8_pack #(.SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_sat), .in_f32(in_f32),
    .out_valid(out_valid_sat), .out_ready(out_ready), .out_fp8(out_fp8_sat), .out_flags(out_flags_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Caller is just after a posedge; returns just after the accepting posedge
  task automatic send(input vec_t v);
    int n = 0;
    in_valid = 1'b1;
    in_f32   = v.f32;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1'b1);
    end else begin
      sb.push_back(v);
    end
    align();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || occ != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Sink readiness: 0 = always ready, 1 = pattern 1,0,0,1, 2 = stalled
  initial begin
    out_ready = 1'b1;
    forever begin
      align();
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
          ph++;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: in_ready model, stall stability, scoreboard compare on every output transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      occ     = 0;
      stalled = 1'b0;
    end else begin
      check("in_ready", in_ready, !(occ == 2 && !out_ready));
      check("in_ready_sat", in_ready_sat, !(occ == 2 && !out_ready));
      if (stalled) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_fp8", out_fp8, held_fp8);
        check("stall_flags", out_flags, held_flags);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("fp8[%h]", mon_e.f32), out_fp8, mon_e.fp8);
          check($sformatf("flags[%h]", mon_e.f32), out_flags, mon_e.flg);
          check($sformatf("sat_valid[%h]", mon_e.f32), out_valid_sat, 1'b1);
          check($sformatf("sat_fp8[%h]", mon_e.f32), out_fp8_sat, mon_e.sat);
          check($sformatf("sat_flags[%h]", mon_e.f32), out_flags_sat, mon_e.flg);
        end
      end
      stalled    = out_valid && !out_ready;
      held_fp8   = out_fp8;
      held_flags = out_flags;
      occ        = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {f32, fp8 (Inf on overflow), flags {ovf,unf,inexact}, fp8 (saturating)}
    vecs[0]  = '{32'h3F800000, 8'h38, 3'b000, 8'h38};  // 1.0
    vecs[1]  = '{32'h43700000, 8'h77, 3'b000, 8'h77};  // 240.0, max finite
    vecs[2]  = '{32'hBF800000, 8'hB8, 3'b000, 8'hB8};  // -1.0
    vecs[3]  = '{32'h3F880000, 8'h38, 3'b001, 8'h38};  // tie -> even
    vecs[4]  = '{32'h3F980000, 8'h3A, 3'b001, 8'h3A};  // tie -> up to even
    vecs[5]  = '{32'h43780000, 8'h78, 3'b101, 8'h77};  // 248 rounds into overflow
    vecs[6]  = '{32'h7FC00000, 8'h7C, 3'b000, 8'h7C};  // qNaN
    vecs[7]  = '{32'hFF800000, 8'hF8, 3'b000, 8'hF8};  // -Inf
    vecs[8]  = '{32'h3B000000, 8'h01, 3'b000, 8'h01};  // 2^-9, min subnormal
    vecs[9]  = '{32'h3A800000, 8'h00, 3'b011, 8'h00};  // 2^-10, tie to zero
    vecs[10] = '{32'h3A000000, 8'h00, 3'b011, 8'h00};  // 2^-11
    vecs[11] = '{32'h00000001, 8'h00, 3'b011, 8'h00};  // FP32 subnormal flush
    vecs[12] = '{32'h80000000, 8'h80, 3'b000, 8'h80};  // -0 keeps sign
    vecs[13] = '{32'hC7800000, 8'hF8, 3'b101, 8'hF7};  // -65536, far overflow
    vecs[14] = '{32'h3AC00000, 8'h01, 3'b011, 8'h01};  // 0.75 ulp rounds up
    vecs[15] = '{32'h3C700000, 8'h08, 3'b011, 8'h08};  // subnormal -> min normal
    vecs[16] = '{32'h7F800000, 8'h78, 3'b000, 8'h78};  // +Inf
    vecs[17] = '{32'h3F900001, 8'h39, 3'b001, 8'h39};  // sticky only
    vecs[18] = '{32'h43740000, 8'h77, 3'b001, 8'h77};  // 244 rounds down

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_f32   = 32'h0000_0000;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_fp8", out_fp8, 8'h00);
    check("rst_out_flags", out_flags, 3'b000);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_sat_valid", out_valid_sat, 1'b0);
    align();
    rst_n = 1'b1;

    // Latency with the sink always ready
    send(vecs[0]);
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 1'b0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1'b1);
    drain();
    align();

    // Full table back to back
    for (int i = 0; i < 19; i++) begin
      send(vecs[i]);
    end
    drain();
    align();

    // Eight samples against a toggling sink
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i + 2]);
    end
    drain();
    rdy_mode = 0;
    align();

    // Fill both stages behind a stalled sink, then reset
    rdy_mode = 2;
    repeat (2) align();
    send(vecs[4]);
    send(vecs[5]);
    @(negedge clk);
    check("full_out_valid", out_valid, 1'b1);
    check("full_in_ready", in_ready, 1'b0);
    align();
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_fp8", out_fp8, 8'h00);
    check("midrst_out_flags", out_flags, 3'b000);
    check("midrst_in_ready", in_ready, 1'b0);
    align();
    rst_n    = 1'b1;
    rdy_mode = 0;
    repeat (2) align();

    send(vecs[1]);
    @(negedge clk);
    check("postrst_cycle1_valid", out_valid, 1'b0);
    @(negedge clk);
    check("postrst_cycle2_valid", out_valid, 1'b1);
    check("postrst_fp8", out_fp8, 8'h77);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
